memory_board_ctl: RTL and testbench

Game-logic controller for the 4x4 memory-card board. Sits between the mouse position delay stage (`xpos`/`ypos`, `left` from the mouse controller) and the card-drawing stage. It resolves clicks to card indices, runs the two-card turn state machine with a timed mismatch reveal, and publishes per-card face-up and matched vectors for the renderer. All logic is in the 65 MHz pixel clock domain.

---
 rtl/memory_board_ctl.sv | 191 +++++++++++++++++++
 tb/tb_memory_board_ctl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_board_ctl.sv
// Purpose : game logic for the 4x4 memory-card board (hit test, two-card turn FSM, mismatch reveal timer).
// Latency : hover 1 clk after xpos/ypos; face_up 2 clk after left is first sampled; match result 1 clk later.
// Backpressure: none; clicks arriving while a turn is being resolved (CHECK/SHOW/DONE) are dropped.
//
// Ports:
//   clk        65 MHz pixel clock
//   rst        asynchronous active-low reset
//   xpos/ypos  mouse position (pixels, already in clk domain)
//   left       mouse left button (asynchronous, synchronised here)
//   new_game   1-cycle pulse: restart game, latch layout
//   layout     card values, card i = layout[3i+2:3i]
//   face_up    per-card shown flags
//   matched    per-card removed-from-play flags
//   hover      card index under cursor, 16 = none
//   pairs      matched pair count (0..8)
//   moves      completed turns, saturating at 255
//   game_over  all 8 pairs found
module memory_board_ctl #(
  parameter int          X0             = 192,
  parameter int          Y0             = 64,
  parameter int          CARD           = 128,
  parameter int          GAP            = 32,
  parameter int          SHOW_CYCLES    = 65_000_000,
  parameter logic [47:0] DEFAULT_LAYOUT = 48'h_FAC688_FAC688
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic        new_game,
  input  logic [47:0] layout,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [4:0]  hover,
  output logic [3:0]  pairs,
  output logic [7:0]  moves,
  output logic        game_over
);

  localparam int             PITCH     = CARD + GAP;
  localparam int             TW        = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES + 1) : 1;
  localparam logic [TW-1:0]  SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [4:0]     NO_CARD   = 5'd16;

  typedef enum logic [2:0] {
    ST_FIRST,
    ST_SECOND,
    ST_CHECK,
    ST_SHOW,
    ST_DONE
  } state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [47:0]   layout_q;
  logic [3:0]    card_a, card_b;
  logic [TW-1:0] timer;

  // Hit test: one range compare pair per column/row, no division.
  logic [1:0] col, row;
  logic       col_ok, row_ok;
  logic [4:0] hit;

  always_comb begin
    col    = 2'd0;
    row    = 2'd0;
    col_ok = 1'b0;
    row_ok = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if ({1'b0, xpos} >= 13'(X0 + c * PITCH) &&
          {1'b0, xpos} <= 13'(X0 + c * PITCH + CARD - 1)) begin
        col    = 2'(c);
        col_ok = 1'b1;
      end
      if ({1'b0, ypos} >= 13'(Y0 + c * PITCH) &&
          {1'b0, ypos} <= 13'(Y0 + c * PITCH + CARD - 1)) begin
        row    = 2'(c);
        row_ok = 1'b1;
      end
    end
    hit = (col_ok && row_ok) ? {1'b0, row, col} : NO_CARD;
  end

  // Card values unpacked from the latched layout.
  logic [2:0] card_val [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      card_val[i] = layout_q[3*i +: 3];
    end
  end

  // Rising edge of the synchronised button; release is ignored.
  logic click;
  logic click_ok;
  logic vals_eq;
  logic [3:0] pairs_inc;

  assign click     = s2 & ~s3;
  // hover[4] set means "no card" (16), so the low bits are only used when it is clear.
  assign click_ok  = click && !hover[4] && !face_up[hover[3:0]] && !matched[hover[3:0]];
  assign vals_eq   = (card_val[card_a] == card_val[card_b]);
  assign pairs_inc = pairs + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FIRST;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      layout_q  <= DEFAULT_LAYOUT;
      card_a    <= 4'd0;
      card_b    <= 4'd0;
      timer     <= '0;
      face_up   <= '0;
      matched   <= '0;
      hover     <= NO_CARD;
      pairs     <= 4'd0;
      moves     <= 8'd0;
      game_over <= 1'b0;
    end else begin
      s1    <= left;
      s2    <= s1;
      s3    <= s2;
      hover <= hit;

      if (new_game) begin
        // Restart wins over everything, including a click landing this cycle.
        state     <= ST_FIRST;
        layout_q  <= layout;
        timer     <= '0;
        face_up   <= '0;
        matched   <= '0;
        pairs     <= 4'd0;
        moves     <= 8'd0;
        game_over <= 1'b0;
      end else begin
        case (state)
          ST_FIRST: begin
            if (click_ok) begin
              face_up[hover[3:0]] <= 1'b1;
              card_a              <= hover[3:0];
              state               <= ST_SECOND;
            end
          end
          ST_SECOND: begin
            // Card A is already face-up, so re-clicking it fails click_ok.
            if (click_ok) begin
              face_up[hover[3:0]] <= 1'b1;
              card_b              <= hover[3:0];
              if (moves != 8'hFF) moves <= moves + 8'd1;
              state               <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (vals_eq) begin
              matched[card_a] <= 1'b1;
              matched[card_b] <= 1'b1;
              pairs           <= pairs_inc;
              if (pairs_inc == 4'd8) begin
                game_over <= 1'b1;
                state     <= ST_DONE;
              end else begin
                state <= ST_FIRST;
              end
            end else begin
              // Counting SHOW_CYCLES-1 down to 0 inclusive gives SHOW_CYCLES clocks in SHOW.
              timer <= SHOW_LOAD;
              state <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (timer == '0) begin
              face_up[card_a] <= 1'b0;
              face_up[card_b] <= 1'b0;
              state           <= ST_FIRST;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: state <= ST_FIRST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_board_ctl.sv
// Purpose : directed bench for memory_board_ctl (hover table plus turn/reveal/reset sequences).
// Latency : checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: n/a.
module tb_memory_board_ctl;

  localparam int SHOW = 10;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic [11:0] xpos     = 12'd0;
  logic [11:0] ypos     = 12'd0;
  logic        left     = 1'b0;
  logic        new_game = 1'b0;
  logic [47:0] layout   = 48'd0;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [4:0]  hover;
  logic [3:0]  pairs;
  logic [7:0]  moves;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_board_ctl #(.SHOW_CYCLES(SHOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .xpos      (xpos),
    .ypos      (ypos),
    .left      (left),
    .new_game  (new_game),
    .layout    (layout),
    .face_up   (face_up),
    .matched   (matched),
    .hover     (hover),
    .pairs     (pairs),
    .moves     (moves),
    .game_over (game_over)
  );

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [4:0]  exp_hover;
  } hv_t;

  hv_t         hv [16];
  logic [2:0]  v1 [16];
  logic [2:0]  v2 [16];
  logic [47:0] lay1, lay2;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ef, input logic [15:0] em,
                            input logic [3:0] ep, input logic [7:0] emv, input logic eg);
    cmp({tag, ".face_up"},   32'(face_up),   32'(ef));
    cmp({tag, ".matched"},   32'(matched),   32'(em));
    cmp({tag, ".pairs"},     32'(pairs),     32'(ep));
    cmp({tag, ".moves"},     32'(moves),     32'(emv));
    cmp({tag, ".game_over"}, 32'(game_over), 32'(eg));
  endtask

  function automatic logic [11:0] cx(input int i);
    return 12'(256 + 160 * (i % 4));
  endfunction

  function automatic logic [11:0] cy(input int i);
    return 12'(128 + 160 * (i / 4));
  endfunction

  // Returns on the falling edge just before the edge where face_up reacts.
  task automatic press_at(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    xpos = x;
    ypos = y;
    repeat (2) @(negedge clk);
    left = 1'b1;
    repeat (2) @(negedge clk);
    left = 1'b0;
  endtask

  task automatic click_at(input logic [11:0] x, input logic [11:0] y);
    press_at(x, y);
    repeat (3) @(negedge clk);
  endtask

  task automatic click(input int i);
    click_at(cx(i), cy(i));
  endtask

  task automatic pulse_new_game(input logic [47:0] lay);
    @(negedge clk);
    new_game = 1'b1;
    layout   = lay;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Hover table: corners, gaps and out-of-grid points.
    hv[0]  = '{12'd256,  12'd128, 5'd0};
    hv[1]  = '{12'd192,  12'd64,  5'd0};
    hv[2]  = '{12'd319,  12'd191, 5'd0};
    hv[3]  = '{12'd320,  12'd128, 5'd16};
    hv[4]  = '{12'd351,  12'd128, 5'd16};
    hv[5]  = '{12'd352,  12'd128, 5'd1};
    hv[6]  = '{12'd330,  12'd128, 5'd16};
    hv[7]  = '{12'd10,   12'd128, 5'd16};
    hv[8]  = '{12'd416,  12'd288, 5'd5};
    hv[9]  = '{12'd799,  12'd671, 5'd15};
    hv[10] = '{12'd800,  12'd671, 5'd16};
    hv[11] = '{12'd672,  12'd544, 5'd15};
    hv[12] = '{12'd672,  12'd543, 5'd16};
    hv[13] = '{12'd191,  12'd128, 5'd16};
    hv[14] = '{12'd256,  12'd63,  5'd16};
    hv[15] = '{12'd4095, 12'd4095, 5'd16};

    v1 = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6,
           3'd7, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    v2 = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
           3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    lay1 = 48'd0;
    lay2 = 48'd0;
    for (int i = 0; i < 16; i++) begin
      lay1[3*i +: 3] = v1[i];
      lay2[3*i +: 3] = v2[i];
    end

    // Reset state (cursor over card 0, hover must still read 16).
    xpos = cx(0);
    ypos = cy(0);
    repeat (3) @(negedge clk);
    check_outs("reset", 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    cmp("reset.hover", 32'(hover), 32'd16);
    rst = 1'b1;

    // Hover: registered one clock after the position changes.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      xpos = hv[i].x;
      ypos = hv[i].y;
      #1;
      if (i > 0) cmp("hover_hold", 32'(hover), 32'(hv[i-1].exp_hover));
      @(negedge clk);
      cmp("hover_tbl", 32'(hover), 32'(hv[i].exp_hover));
    end

    // Default layout after reset: cards 0 and 8 share value 0.
    click(0);
    cmp("dflt.first", 32'(face_up), 32'h0001);
    click(8);
    check_outs("dflt_match", 16'h0101, 16'h0101, 4'd1, 8'd1, 1'b0);

    // new_game coinciding with a click on card 2: click dropped, state cleared.
    @(negedge clk);
    xpos = cx(2);
    ypos = cy(2);
    repeat (2) @(negedge clk);
    left = 1'b1;
    repeat (2) @(negedge clk);
    new_game = 1'b1;
    layout   = lay1;
    @(negedge clk);
    new_game = 1'b0;
    left     = 1'b0;
    repeat (4) @(negedge clk);
    check_outs("newgame_drop", 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);

    // Match on cards 0 and 5; matched follows face_up by one clock.
    click(0);
    check_outs("match.first", 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    press_at(cx(5), cy(5));
    @(negedge clk);
    check_outs("match.second", 16'h0021, 16'h0, 4'd0, 8'd1, 1'b0);
    @(negedge clk);
    check_outs("match.check", 16'h0021, 16'h0021, 4'd1, 8'd1, 1'b0);

    // Invalid clicks: gap, outside grid, matched card, same card twice.
    click_at(12'd330, 12'd128);
    click_at(12'd10, 12'd128);
    click(0);
    check_outs("invalid", 16'h0021, 16'h0021, 4'd1, 8'd1, 1'b0);
    click(1);
    click(1);
    check_outs("same_twice", 16'h0023, 16'h0021, 4'd1, 8'd1, 1'b0);

    // Mismatch 1 vs 2: visible for CHECK + SHOW clocks, then both clear together.
    press_at(cx(2), cy(2));
    @(negedge clk);
    check_outs("mis.set", 16'h0027, 16'h0021, 4'd1, 8'd2, 1'b0);
    repeat (10) @(negedge clk);
    cmp("mis.last_visible", 32'(face_up), 32'h0027);
    @(negedge clk);
    cmp("mis.cleared", 32'(face_up), 32'h0021);

    // Mismatch 3 vs 4 with a click on card 7 during SHOW.
    click(3);
    click(4);
    click(7);
    check_outs("show_click", 16'h0039, 16'h0021, 4'd1, 8'd3, 1'b0);
    repeat (5) @(negedge clk);
    check_outs("show_end", 16'h0021, 16'h0021, 4'd1, 8'd3, 1'b0);

    // Click latency and single click for a long press.
    @(negedge clk);
    xpos = cx(6);
    ypos = cy(6);
    repeat (2) @(negedge clk);
    left = 1'b1;
    @(negedge clk);
    cmp("lat.k", 32'(face_up[6]), 32'd0);
    @(negedge clk);
    cmp("lat.k1", 32'(face_up[6]), 32'd0);
    @(negedge clk);
    cmp("lat.k2", 32'(face_up[6]), 32'd1);
    xpos = cx(7);
    ypos = cy(7);
    repeat (100) @(negedge clk);
    left = 1'b0;
    repeat (3) @(negedge clk);
    cmp("long_press", 32'(face_up), 32'h0061);
    click(6);
    cmp("reclick_a", 32'(face_up), 32'h0061);
    click(13);
    check_outs("pair2", 16'h2061, 16'h2061, 4'd2, 8'd4, 1'b0);

    // Finish the game.
    click(1);  click(9);
    click(2);  click(10);
    click(3);  click(11);
    click(4);  click(12);
    click(7);  click(14);
    check_outs("pair7", 16'h7EFF, 16'h7EFF, 4'd7, 8'd9, 1'b0);
    click(8);
    press_at(cx(15), cy(15));
    @(negedge clk);
    check_outs("last.second", 16'hFFFF, 16'h7EFF, 4'd7, 8'd10, 1'b0);
    @(negedge clk);
    check_outs("game_over", 16'hFFFF, 16'hFFFF, 4'd8, 8'd10, 1'b1);
    click(0);
    click(5);
    check_outs("done_click", 16'hFFFF, 16'hFFFF, 4'd8, 8'd10, 1'b1);

    // New game with a layout where cards 0 and 1 pair up.
    pulse_new_game(lay2);
    check_outs("newgame", 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    click(0);
    click(1);
    check_outs("new_layout", 16'h0003, 16'h0003, 4'd1, 8'd1, 1'b0);

    // Reset asserted mid-SHOW acts immediately.
    click(2);
    click(4);
    check_outs("pre_rst", 16'h0017, 16'h0003, 4'd1, 8'd2, 1'b0);
    rst = 1'b0;
    #1;
    check_outs("rst_show", 16'h0, 16'h0, 4'd0, 8'd0, 1'b0);
    cmp("rst_show.hover", 32'(hover), 32'd16);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    click(0);
    check_outs("post_rst.first", 16'h0001, 16'h0, 4'd0, 8'd0, 1'b0);
    click(8);
    check_outs("post_rst.match", 16'h0101, 16'h0101, 4'd1, 8'd1, 1'b0);

    // moves saturates at 255 (default layout: cards 2 and 3 differ).
    for (int t = 0; t < 254; t++) begin
      click(2);
      click(3);
      repeat (10) @(negedge clk);
    end
    check_outs("moves_255", 16'h0101, 16'h0101, 4'd1, 8'd255, 1'b0);
    click(2);
    click(3);
    repeat (10) @(negedge clk);
    check_outs("moves_sat", 16'h0101, 16'h0101, 4'd1, 8'd255, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
